// File: rtl/pim_alu_io_retimer.sv
// I/O retiming stage between the PIM command/data interface and the bank ALU cores.
// It also holds the bank configuration register, which is committed only while all channels are quiet.
module pim_alu_io_retimer #(
  parameter int DATA_W     = 256,
  parameter int CFG_W      = 28,
  parameter int NUM_CH     = 1,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int QUIET_CYC  = 4,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(28'h851F)
) (
  input  logic                     clk,
  input  logic                     rst_x,
  input  logic [NUM_CH-1:0]        hpc_clear_i,
  input  logic [NUM_CH-1:0]        src_a_rd_i,
  input  logic [NUM_CH-1:0]        src_b_rd_i,
  input  logic [NUM_CH-1:0]        dst_c_wr_i,
  input  logic [NUM_CH-1:0]        vec_a_wr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  input  logic [NUM_CH*DATA_W-1:0] dram_data_i,
  input  logic                     cfg_wr_en_i,
  input  logic [CFG_W-1:0]         cfg_wr_data_i,
  input  logic [NUM_CH*DATA_W-1:0] core_result_i,
  output logic [NUM_CH-1:0]        hpc_clear_o,
  output logic [NUM_CH-1:0]        src_a_rd_o,
  output logic [NUM_CH-1:0]        src_b_rd_o,
  output logic [NUM_CH-1:0]        dst_c_wr_o,
  output logic [NUM_CH-1:0]        vec_a_wr_o,
  output logic [NUM_CH*DATA_W-1:0] req_data_o,
  output logic [NUM_CH*DATA_W-1:0] dram_data_o,
  output logic [CFG_W-1:0]         bank_cfg_o,
  output logic [NUM_CH*DATA_W-1:0] result_o,
  output logic                     cfg_pending_o,
  output logic                     cfg_applied_o
);

  localparam int RW = NUM_CH * DATA_W;
  localparam int IW = 5 * NUM_CH + 2 * RW;
  localparam int QW = $clog2(QUIET_CYC + 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(QUIET_CYC);

  logic [IW-1:0]    in_bus_s;
  logic [IW-1:0]    in_pipe_r [IN_STAGES];
  logic [RW-1:0]    out_pipe_r [OUT_STAGES];
  logic             strobe_any_s;
  logic             commit_s;
  logic [QW-1:0]    quiet_r;
  logic             pend_r;
  logic [CFG_W-1:0] pend_val_r;
  logic [CFG_W-1:0] cfg_r;
  logic             applied_r;

  assign in_bus_s = {hpc_clear_i, src_a_rd_i, src_b_rd_i, dst_c_wr_i, vec_a_wr_i,
                     req_data_i, dram_data_i};

  // Input retiming chain: strobes and data travel together, no enable.
  always_ff @(posedge clk or posedge rst_x) begin
    if (rst_x) begin
      for (int i = 0; i < IN_STAGES; i++) in_pipe_r[i] <= '0;
    end else begin
      in_pipe_r[0] <= in_bus_s;
      for (int i = 1; i < IN_STAGES; i++) in_pipe_r[i] <= in_pipe_r[i-1];
    end
  end

  // Result retiming chain from the cores back to the interface.
  always_ff @(posedge clk or posedge rst_x) begin
    if (rst_x) begin
      for (int i = 0; i < OUT_STAGES; i++) out_pipe_r[i] <= '0;
    end else begin
      out_pipe_r[0] <= core_result_i;
      for (int i = 1; i < OUT_STAGES; i++) out_pipe_r[i] <= out_pipe_r[i-1];
    end
  end

  assign {hpc_clear_o, src_a_rd_o, src_b_rd_o, dst_c_wr_o, vec_a_wr_o,
          req_data_o, dram_data_o} = in_pipe_r[IN_STAGES-1];
  assign result_o = out_pipe_r[OUT_STAGES-1];

  // Quiet detection and commit qualification; a write in the same cycle defers the commit.
  always_comb begin
    strobe_any_s = |{hpc_clear_i, src_a_rd_i, src_b_rd_i, dst_c_wr_i, vec_a_wr_i};
    if (pend_r && (quiet_r == QUIET_MAX) && !strobe_any_s && !cfg_wr_en_i) begin
      commit_s = 1'b1;
    end else begin
      commit_s = 1'b0;
    end
  end

  // Configuration state: quiet counter, last-wins pending value, active config and applied pulse.
  always_ff @(posedge clk or posedge rst_x) begin
    if (rst_x) begin
      quiet_r    <= QUIET_MAX;
      pend_r     <= 1'b0;
      pend_val_r <= '0;
      cfg_r      <= CFG_DEFAULT;
      applied_r  <= 1'b0;
    end else begin
      if (strobe_any_s) begin
        quiet_r <= '0;
      end else if (quiet_r != QUIET_MAX) begin
        quiet_r <= quiet_r + QW'(1);
      end else begin
        quiet_r <= quiet_r;
      end
      if (cfg_wr_en_i) begin
        pend_val_r <= cfg_wr_data_i;
        pend_r     <= 1'b1;
      end else if (commit_s) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
      if (commit_s) begin
        cfg_r <= pend_val_r;
      end else begin
        cfg_r <= cfg_r;
      end
      applied_r <= commit_s;
    end
  end

  assign bank_cfg_o    = cfg_r;
  assign cfg_pending_o = pend_r;
  assign cfg_applied_o = applied_r;

endmodule

// File: tb/tb_pim_alu_io_retimer.sv
// Scoreboard bench for pim_alu_io_retimer: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares them after every clock edge.
module tb_pim_alu_io_retimer;
  localparam int DW = 64;
  localparam int NCH = 4;
  localparam int INS = 2;
  localparam int OUTS = 1;
  localparam int QC = 4;
  localparam int CW = 28;
  localparam int RW = NCH * DW;
  localparam logic [CW-1:0] CFG_DEF = 28'h851F;

  logic clk = 1'b0;
  logic rst_x = 1'b1;
  logic [NCH-1:0] hpc_i = '0, sa_i = '0, sb_i = '0, dc_i = '0, va_i = '0;
  logic [RW-1:0]  req_i = '0, dram_i = '0, res_i = '0;
  logic           wr_en = 1'b0;
  logic [CW-1:0]  wr_data = '0;
  logic [NCH-1:0] hpc_o, sa_o, sb_o, dc_o, va_o;
  logic [RW-1:0]  req_o, dram_o, res_o;
  logic [CW-1:0]  cfg_o;
  logic           pend_o, appl_o;

  pim_alu_io_retimer #(.DATA_W(DW), .CFG_W(CW), .NUM_CH(NCH), .IN_STAGES(INS),
                       .OUT_STAGES(OUTS), .QUIET_CYC(QC), .CFG_DEFAULT(CFG_DEF)) dut (
    .clk(clk), .rst_x(rst_x),
    .hpc_clear_i(hpc_i), .src_a_rd_i(sa_i), .src_b_rd_i(sb_i), .dst_c_wr_i(dc_i),
    .vec_a_wr_i(va_i), .req_data_i(req_i), .dram_data_i(dram_i),
    .cfg_wr_en_i(wr_en), .cfg_wr_data_i(wr_data), .core_result_i(res_i),
    .hpc_clear_o(hpc_o), .src_a_rd_o(sa_o), .src_b_rd_o(sb_o), .dst_c_wr_o(dc_o),
    .vec_a_wr_o(va_o), .req_data_o(req_o), .dram_data_o(dram_o),
    .bank_cfg_o(cfg_o), .result_o(res_o), .cfg_pending_o(pend_o), .cfg_applied_o(appl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] hpc, sa, sb, dc, va;
    logic [RW-1:0]  req, dram, res;
    logic           wr;
    logic [CW-1:0]  wdata;
  } in_t;

  typedef struct {
    logic [NCH-1:0] hpc, sa, sb, dc, va;
    logic [RW-1:0]  req, dram, res;
    logic [CW-1:0]  cfg;
    logic           pend, appl;
  } exp_t;

  exp_t exp_q[$];
  in_t  hist[$];
  int   n_checks = 0;
  int   n_err = 0;

  // reference model state: a delay line of applied inputs plus the config rules
  logic          m_pend;
  logic [CW-1:0] m_pval, m_cfg;
  int            m_quiet;

  task automatic chk(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rnd_bus();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x.hpc = '0; x.sa = '0; x.sb = '0; x.dc = '0; x.va = '0;
    x.req = rnd_bus(); x.dram = rnd_bus(); x.res = rnd_bus();
    x.wr = 1'b0; x.wdata = '0;
    return x;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pend = 1'b0; m_pval = '0; m_cfg = CFG_DEF; m_quiet = QC;
  endtask

  // Apply one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic drive(in_t x);
    exp_t e;
    bit   any, commit;
    @(negedge clk);
    hpc_i = x.hpc; sa_i = x.sa; sb_i = x.sb; dc_i = x.dc; va_i = x.va;
    req_i = x.req; dram_i = x.dram; res_i = x.res; wr_en = x.wr; wr_data = x.wdata;
    any = |{x.hpc, x.sa, x.sb, x.dc, x.va};
    commit = m_pend && (m_quiet == QC) && !any && !x.wr;
    if (commit) begin m_cfg = m_pval; m_pend = 1'b0; end
    if (x.wr) begin m_pval = x.wdata; m_pend = 1'b1; end
    m_quiet = any ? 0 : ((m_quiet < QC) ? m_quiet + 1 : QC);
    hist.push_front(x);
    if (hist.size() > 4) void'(hist.pop_back());
    e.hpc = '0; e.sa = '0; e.sb = '0; e.dc = '0; e.va = '0; e.req = '0; e.dram = '0; e.res = '0;
    if (hist.size() >= INS) begin
      e.hpc = hist[INS-1].hpc; e.sa = hist[INS-1].sa; e.sb = hist[INS-1].sb;
      e.dc = hist[INS-1].dc; e.va = hist[INS-1].va;
      e.req = hist[INS-1].req; e.dram = hist[INS-1].dram;
    end
    if (hist.size() >= OUTS) e.res = hist[OUTS-1].res;
    e.cfg = m_cfg; e.pend = m_pend; e.appl = commit;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge out of reset presents a full output set to compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst_x && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hpc_clear", RW'(hpc_o), RW'(e.hpc));
      chk("src_a_rd", RW'(sa_o), RW'(e.sa));
      chk("src_b_rd", RW'(sb_o), RW'(e.sb));
      chk("dst_c_wr", RW'(dc_o), RW'(e.dc));
      chk("vec_a_wr", RW'(va_o), RW'(e.va));
      chk("req_data", req_o, e.req);
      chk("dram_data", dram_o, e.dram);
      chk("result", res_o, e.res);
      chk("bank_cfg", RW'(cfg_o), RW'(e.cfg));
      chk("cfg_pending", RW'(pend_o), RW'(e.pend));
      chk("cfg_applied", RW'(appl_o), RW'(e.appl));
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_strobes"}, RW'({hpc_o, sa_o, sb_o, dc_o, va_o}), '0);
    chk({tag, "_req"}, req_o, '0);
    chk({tag, "_dram"}, dram_o, '0);
    chk({tag, "_result"}, res_o, '0);
    chk({tag, "_cfg"}, RW'(cfg_o), RW'(CFG_DEF));
    chk({tag, "_pending"}, RW'(pend_o), '0);
    chk({tag, "_applied"}, RW'(appl_o), '0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(idle_in());
  endtask

  initial begin
    in_t x;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_x = 1'b0;

    // latency: strobe + A5 pattern on channel 0, and a known result word
    x = idle_in();
    x.sa[0] = 1'b1;
    x.req[DW-1:0] = {(DW/8){8'hA5}};
    x.res = RW'(64'h1234);
    drive(x);
    idle(6);

    // idle write commits on the following edge
    x = idle_in(); x.wr = 1'b1; x.wdata = 28'h0001234;
    drive(x);
    idle(4);

    // write during continuous dst_c_wr traffic on channel 3
    for (int i = 0; i < 6; i++) begin
      x = idle_in(); x.dc[3] = 1'b1;
      if (i == 0) begin x.wr = 1'b1; x.wdata = 28'hABCDEF0; end
      drive(x);
    end
    idle(8);

    // two writes while busy: last value wins
    for (int i = 0; i < 4; i++) begin
      x = idle_in(); x.dc[1] = 1'b1;
      if (i == 0) begin x.wr = 1'b1; x.wdata = 28'h0000111; end
      if (i == 1) begin x.wr = 1'b1; x.wdata = 28'h0000222; end
      drive(x);
    end
    idle(8);

    // write landing exactly in the commit-eligible cycle
    x = idle_in(); x.wr = 1'b1; x.wdata = 28'h0000333;
    drive(x);
    x = idle_in(); x.wr = 1'b1; x.wdata = 28'h0000444;
    drive(x);
    idle(3);

    // rewriting the current value still commits and pulses
    x = idle_in(); x.wr = 1'b1; x.wdata = 28'h0000444;
    drive(x);
    idle(3);

    // randomized traffic with sporadic strobes and writes
    for (int i = 0; i < 400; i++) begin
      x = idle_in();
      if ($urandom_range(0, 3) == 0) begin
        x.hpc = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
        x.sa = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
        x.sb = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
        x.dc = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
        x.va = NCH'($urandom_range(0, 15) & $urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) begin x.wr = 1'b1; x.wdata = CW'($urandom); end
      drive(x);
    end

    // asynchronous reset with a write pending and strobes in flight
    x = idle_in(); x.sb = 4'hF; x.wr = 1'b1; x.wdata = 28'h0BEEF00;
    drive(x);
    x = idle_in(); x.va = 4'h5;
    drive(x);
    @(posedge clk);
    #3;
    rst_x = 1'b1;
    hpc_i = '0; sa_i = '0; sb_i = '0; dc_i = '0; va_i = '0;
    req_i = '0; dram_i = '0; res_i = '0; wr_en = 1'b0; wr_data = '0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_x = 1'b0;
    idle(6);
    x = idle_in(); x.wr = 1'b1; x.wdata = 28'h0C0FFEE;
    drive(x);
    idle(3);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", RW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
